// File: rtl/sync_fifo_param_pkg.sv
// sync_fifo_param_pkg: shared sizing helper, default geometry and strobe bundle for the parametrised FIFO
package sync_fifo_param_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH = 8;
  typedef struct packed {
    logic wr_ack;
    logic wr_err;
    logic rd_ack;
    logic rd_err;
  } strobe_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: FIFO request/response bundle; master = producer/consumer side, slave = FIFO
interface sync_fifo_param_if
  import sync_fifo_param_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int CNT_W = clog2(DEPTH) + 1;
  logic wr_en;
  logic [DATA_W-1:0] din;
  logic rd_en;
  logic [DATA_W-1:0] dout;
  logic full;
  logic empty;
  logic almost_full;
  logic almost_empty;
  logic wr_ack;
  logic wr_err;
  logic rd_ack;
  logic rd_err;
  logic [CNT_W-1:0] data_count;
  modport master (
    output wr_en, din, rd_en,
    input dout, full, empty, almost_full, almost_empty, wr_ack, wr_err, rd_ack, rd_err, data_count
  );
  modport slave (
    input wr_en, din, rd_en,
    output dout, full, empty, almost_full, almost_empty, wr_ack, wr_err, rd_ack, rd_err, data_count
  );
endinterface

// File: rtl/fifo_mem_param.sv
// fifo_mem_param: DEPTH x DATA_W register file, sync write / comb read, unreset (ports: clk, we, waddr, wdata, raddr, rdata)
module fifo_mem_param
  import sync_fifo_param_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input logic clk,
  input logic we,
  input logic [ADDR_W-1:0] waddr,
  input logic [DATA_W-1:0] wdata,
  input logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy flags and per-request ack/err strobes (ports: clk, reset_n async active-low, bus slave modport)
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AF_LVL = 6,
  parameter int AE_LVL = 2,
  localparam int ADDR_W = clog2(DEPTH),
  localparam int CNT_W = ADDR_W + 1
) (
  input logic clk,
  input logic reset_n,
  sync_fifo_param_if.slave bus
);
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [DATA_W-1:0] dout_q, rdata;
  strobe_t stb;
  logic wr_ok, rd_ok;
  // Acceptance uses the pre-edge flags, so a full FIFO refuses a write even if a read drains it this cycle.
  assign wr_ok = bus.wr_en && !bus.full;
  assign rd_ok = bus.rd_en && !bus.empty;
  fifo_mem_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(wr_ok),
    .waddr(wr_ptr),
    .wdata(bus.din),
    .raddr(rd_ptr),
    .rdata(rdata)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      dout_q <= '0;
      stb <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
      if (rd_ok) dout_q <= rdata;
      count <= (wr_ok && !rd_ok) ? count + CNT_W'(1) : (rd_ok && !wr_ok) ? count - CNT_W'(1) : count;
      stb <= '{wr_ack: wr_ok, wr_err: bus.wr_en && !wr_ok, rd_ack: rd_ok, rd_err: bus.rd_en && !rd_ok};
    end
  end
  assign bus.dout = dout_q;
  assign bus.data_count = count;
  assign bus.full = count == CNT_W'(DEPTH);
  assign bus.empty = count == '0;
  assign bus.almost_full = count >= CNT_W'(AF_LVL);
  assign bus.almost_empty = count <= CNT_W'(AE_LVL);
  assign bus.wr_ack = stb.wr_ack;
  assign bus.wr_err = stb.wr_err;
  assign bus.rd_ack = stb.rd_ack;
  assign bus.rd_err = stb.rd_err;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed self-checking bench for sync_fifo_param (32x8, AF 6, AE 2)
module tb_sync_fifo_param;
  logic clk;
  logic reset_n;
  int total;
  int bad;
  sync_fifo_param_if #(.DATA_W(32), .DEPTH(8)) bus ();
  sync_fifo_param #(.DATA_W(32), .DEPTH(8), .AF_LVL(6), .AE_LVL(2)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic w, input logic [31:0] d, input logic r);
    @(negedge clk);
    bus.wr_en = w;
    bus.din = d;
    bus.rd_en = r;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] strobes();
    return {28'd0, bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err};
  endfunction
  task automatic chk_idle_reset(input string tag);
    chk({tag, "_empty"}, {31'd0, bus.empty}, 1);
    chk({tag, "_aempty"}, {31'd0, bus.almost_empty}, 1);
    chk({tag, "_full"}, {31'd0, bus.full}, 0);
    chk({tag, "_afull"}, {31'd0, bus.almost_full}, 0);
    chk({tag, "_count"}, {28'd0, bus.data_count}, 0);
    chk({tag, "_dout"}, bus.dout, 0);
    chk({tag, "_strobes"}, strobes(), 0);
  endtask
  initial begin
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk_idle_reset("reset");
    step(0, 0, 0);
    chk_idle_reset("idle");
    for (int i = 1; i <= 8; i++) begin
      step(1, i, 0);
      chk($sformatf("wr%0d_ack", i), {31'd0, bus.wr_ack}, 1);
      chk($sformatf("wr%0d_cnt", i), {28'd0, bus.data_count}, i);
      chk($sformatf("wr%0d_af", i), {31'd0, bus.almost_full}, (i >= 6) ? 1 : 0);
      chk($sformatf("wr%0d_full", i), {31'd0, bus.full}, (i == 8) ? 1 : 0);
      chk($sformatf("wr%0d_ae", i), {31'd0, bus.almost_empty}, (i <= 2) ? 1 : 0);
    end
    step(1, 32'h99, 0);
    chk("wr9_strobes", strobes(), 32'b0100);
    chk("wr9_cnt", {28'd0, bus.data_count}, 8);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 1);
      chk($sformatf("rd%0d_dout", i), bus.dout, i);
      chk($sformatf("rd%0d_ack", i), strobes(), 32'b0010);
      chk($sformatf("rd%0d_cnt", i), {28'd0, bus.data_count}, 8 - i);
    end
    step(0, 0, 1);
    chk("rd9_strobes", strobes(), 32'b0001);
    chk("rd9_dout", bus.dout, 8);
    chk("rd9_empty", {31'd0, bus.empty}, 1);
    for (int i = 0; i < 5; i++) step(1, 32'h10 + i, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1);
      chk($sformatf("wrap5_rd%0d", i), bus.dout, 32'h10 + i);
    end
    for (int i = 0; i < 6; i++) step(1, 32'hA0 + i, 0);
    chk("wrap6_cnt_full", {28'd0, bus.data_count}, 6);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1);
      chk($sformatf("wrap6_rd%0d", i), bus.dout, 32'hA0 + i);
    end
    chk("wrap_cnt", {28'd0, bus.data_count}, 0);
    step(1, 32'h55, 1);
    chk("sim0_cnt", {28'd0, bus.data_count}, 1);
    chk("sim0_strobes", strobes(), 32'b1001);
    chk("sim0_dout", bus.dout, 32'hA5);
    for (int i = 0; i < 3; i++) step(1, 32'h56 + i, 0);
    step(1, 32'h60, 1);
    chk("sim4_cnt", {28'd0, bus.data_count}, 4);
    chk("sim4_strobes", strobes(), 32'b1010);
    chk("sim4_dout", bus.dout, 32'h55);
    for (int i = 0; i < 4; i++) step(1, 32'h61 + i, 0);
    chk("sim8_pre_full", {31'd0, bus.full}, 1);
    step(1, 32'h77, 1);
    chk("sim8_cnt", {28'd0, bus.data_count}, 7);
    chk("sim8_strobes", strobes(), 32'b0110);
    chk("sim8_dout", bus.dout, 32'h56);
    step(0, 0, 1);
    chk("drain_dout57", bus.dout, 32'h57);
    step(0, 0, 1);
    chk("drain_dout58", bus.dout, 32'h58);
    chk("pre_reset_cnt", {28'd0, bus.data_count}, 5);
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.din = 32'hEE;
    bus.rd_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk_idle_reset("async_rst");
    @(negedge clk);
    bus.wr_en = 1'b0;
    reset_n = 1'b1;
    step(0, 0, 1);
    chk("post_rst_strobes", strobes(), 32'b0001);
    chk("post_rst_cnt", {28'd0, bus.data_count}, 0);
    chk("post_rst_dout", bus.dout, 0);
    step(0, 0, 0);
    chk("final_strobes", strobes(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
